// File: rtl/keccak_padder_gen.sv
// -----------------------------------------------------------------------------
// keccak_padder_gen
//
// Packs a stream of message words into RATE-bit blocks for a Keccak / SHA-3
// permutation core and applies multi-rate padding to the final block.
//
// The block is a shift register. Each appended word enters at the bottom, so
// the first word of a block ends up in the top WORD_W bits. After the final
// (possibly partial) message word, the padder appends filler words by itself
// until the block is full. The last byte of the block carries the 0x80
// pad-end bit.
//
// Parameters
//   WORD_W  input word width in bits (32 or 64)
//   RATE    block width in bits (1152, 1088, 832 or 576), a multiple of WORD_W
//   DOMAIN  padding start byte (8'h01 Keccak, 8'h06 SHA-3)
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   in           message word, first byte in the top byte lane
//   in_ready     in is valid this cycle
//   is_last      in is the final (possibly partial) message word
//   byte_num     number of valid leading bytes of the final word
//   buffer_full  a complete block is held in out (registered)
//   out          padded block, first word in the top WORD_W bits
//   out_ready    same as buffer_full
//   f_ack        one-cycle pulse from the permutation core: block consumed
//
// FSM
//   state | meaning
//   FILL  | accepting message words from upstream
//   PAD   | final word taken, appending zero words up to the pad-end word
//   DONE  | padded block complete; input ignored until reset
// -----------------------------------------------------------------------------
module keccak_padder_gen #(
    parameter int         WORD_W = 32,
    parameter int         RATE   = 576,
    parameter logic [7:0] DOMAIN = 8'h01
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WORD_W-1:0]             in,
    input  logic                          in_ready,
    input  logic                          is_last,
    input  logic [$clog2(WORD_W/8)-1:0]   byte_num,
    output logic                          buffer_full,
    output logic [RATE-1:0]               out,
    output logic                          out_ready,
    input  logic                          f_ack
);

    localparam int BYTES   = WORD_W / 8;
    localparam int N_WORDS = RATE / WORD_W;
    localparam int CNT_W   = $clog2(N_WORDS + 1);

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(N_WORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_WORDS - 1);
    localparam logic [WORD_W-1:0] PAD_END  = WORD_W'(8'h80);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              room;
    logic              ack;
    logic              append;
    logic [WORD_W-1:0] append_word;
    logic [WORD_W-1:0] last_word;

    // buffer_full lags cnt by one edge. While cnt sits at CNT_FULL and the flag
    // has not risen yet, room must still block acceptance. Otherwise a word
    // held by upstream would overflow the block.
    assign room      = ~buffer_full & (cnt != CNT_FULL);
    assign ack       = f_ack & buffer_full;
    assign out_ready = buffer_full;

    // Final-word formatting: keep the leading byte_num bytes, insert the
    // domain byte right after them, and zero the rest. If this word also
    // closes the block, the pad-end bit is merged into its last byte.
    always_comb begin
        last_word = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i < int'(byte_num))
                last_word[WORD_W-1-8*i -: 8] = in[WORD_W-1-8*i -: 8];
            else if (i == int'(byte_num))
                last_word[WORD_W-1-8*i -: 8] = DOMAIN;
            else
                last_word[WORD_W-1-8*i -: 8] = 8'h00;
        end
        if (cnt == CNT_LAST)
            last_word[7:0] = last_word[7:0] | 8'h80;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= FILL;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        append      = 1'b0;
        append_word = in;
        case (state)
            FILL: begin
                if (in_ready && room) begin
                    append = 1'b1;
                    if (is_last) begin
                        append_word = last_word;
                        state_next  = (cnt == CNT_LAST) ? DONE : PAD;
                    end
                end
            end
            PAD: begin
                // Runs on its own; in_ready plays no part here.
                if (room) begin
                    append = 1'b1;
                    if (cnt == CNT_LAST) begin
                        append_word = PAD_END;
                        state_next  = DONE;
                    end else begin
                        append_word = '0;
                    end
                end
            end
            default: begin
                // DONE: hold until reset.
            end
        endcase
    end

    // Block datapath. An acknowledge clears the block and blocks any append
    // on the same edge. Acceptance therefore resumes one cycle after f_ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            out         <= '0;
            cnt         <= '0;
            buffer_full <= 1'b0;
        end else if (ack) begin
            out         <= '0;
            cnt         <= '0;
            buffer_full <= 1'b0;
        end else begin
            buffer_full <= (cnt == CNT_FULL);
            if (append) begin
                out <= {out[RATE-WORD_W-1:0], append_word};
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/keccak_padder_gen.md
KECCAK_PADDER_GEN -- requirements
Module: keccak_padder_gen

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning input word width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter RATE, default 576, meaning block width in bits; legal values 1152, 1088, 832, 576; must be a multiple of WORD_W.
REQ-003 SHALL have parameter DOMAIN, default 8'h01, meaning the padding start byte: 8'h01 for Keccak, 8'h06 for SHA-3.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-006 SHALL have port in, input, WORD_W bits, the message word; the first byte is in bits [WORD_W-1:WORD_W-8].
REQ-007 SHALL have port in_ready, input, 1 bit, meaning `in` is valid this cycle.
REQ-008 SHALL have port is_last, input, 1 bit, marking the final (possibly partial) word.
REQ-009 SHALL have port byte_num, input, clog2(WORD_W/8) bits, giving the count of valid leading bytes when is_last is high; its range is 0..WORD_W/8-1.
REQ-010 SHALL have port buffer_full, output, 1 bit, meaning a complete block is held.
REQ-011 SHALL have port out, output, RATE bits, the padded block; the first word is in bits [RATE-1:RATE-WORD_W].
REQ-012 SHALL have port out_ready, output, 1 bit, equal to buffer_full.
REQ-013 SHALL have port f_ack, input, 1 bit, a single-cycle pulse from the permutation core meaning the block has been consumed.

Function
REQ-014 SHALL hold the block in a shift register: each appended word gives out <= {out[RATE-WORD_W-1:0], word}; a counter `cnt` runs 0..RATE/WORD_W.
REQ-015 SHALL implement states FILL, PAD and DONE; FILL is the reset state.
REQ-016 In FILL, a word SHALL be accepted when in_ready=1 and buffer_full=0; with in_ready=1 and buffer_full=1 the word SHALL NOT be accepted, and upstream holds it.
REQ-017 An accepted word with is_last=0 SHALL be appended unchanged.
REQ-018 An accepted word with is_last=1 SHALL be appended with its first byte_num bytes kept, the next byte set to DOMAIN, and the remaining bytes zeroed.
REQ-019 If the is_last word fills the block (cnt reaches RATE/WORD_W), its least-significant byte SHALL additionally be ORed with 8'h80, and the state SHALL go to DONE.
REQ-020 If the is_last word does not fill the block, the state SHALL go to PAD.
REQ-021 In PAD, the block SHALL append one all-zero word per cycle, independent of in_ready.
REQ-022 In PAD, the word that completes the block SHALL be WORD_W'h80 (the pad-end bit), and the state SHALL then go to DONE.
REQ-023 buffer_full SHALL be registered, and SHALL rise in the cycle after the edge on which cnt reaches RATE/WORD_W.
REQ-024 When f_ack=1 with buffer_full=1, the next edge SHALL clear out to 0, cnt to 0 and buffer_full to 0; no word is accepted on that edge.
REQ-025 An f_ack pulse while buffer_full=0 SHALL be ignored.
REQ-026 In DONE, after the final block is acknowledged, further input SHALL be ignored until reset; buffer_full stays 0 and out stays 0.
REQ-027 A non-final full block SHALL keep the state in FILL; acceptance resumes the cycle after f_ack.

Reset
REQ-028 When reset=1 at a clock edge, the block SHALL set state=FILL, cnt=0, out=0, buffer_full=0 and out_ready=0.
REQ-029 Reset SHALL take priority over in_ready, f_ack and PAD progress, including mid-block and mid-PAD.

Verification
REQ-030 Reset check: assert reset for one cycle -> out=0, buffer_full=0, out_ready=0 on the next cycle.
REQ-031 Partial last word (WORD_W=32, RATE=576, DOMAIN=01): send "Hell","o, w","orld", then "!   " with byte_num=1 and is_last=1.
  - Top 128 bits of out = 48656c6c_6f2c2077_6f726c64_21010000.
  - Words 5-17 = 0; word 18 = 00000080.
  - buffer_full rises 15 cycles after the is_last edge (14 PAD appends, then the registered flag).
REQ-032 Exact-fit last word (WORD_W=32, RATE=576): send 17 full words, then an 18th word 0x41424344 with byte_num=3 and is_last=1 -> last word = 0x41424381, no PAD cycles, buffer_full rises next cycle.
REQ-033 Backpressure (WORD_W=32, RATE=576): send 18 non-last words with in_ready held high -> buffer_full=1, the 19th word is not accepted while buffer_full=1; pulse f_ack -> out=0 next cycle, then the 19th word is accepted at cnt=0 and the second block completes correctly.
REQ-034 Empty message (WORD_W=64, RATE=1088, DOMAIN=06): in=0, byte_num=0, is_last=1 -> word 1 = 0600000000000000, words 2-16 = 0, word 17 = 0000000000000080.
REQ-035 Reset mid-operation: assert reset during PAD (cnt=7) -> all outputs 0 next cycle; a following "Hell","o, w","orld", "!   " (byte_num=1, is_last=1) message produces the REQ-031 block.
